pmctrl: RTL and testbench
=========================

# pmctrl

Instruction sequencer for the 3-register/accumulator datapath (`pmdatapath`). It accepts one 12-bit instruction at a time over a valid/ready handshake. It then drives the datapath control lines `w`, `ce`, `sel`, `s`, `cin` and `clr` over 1–3 cycles to load registers from the external inputs, clear them, or run a two-operand ALU operation with optional write-back. It sits between the instruction source and the datapath, and is the only driver of the datapath's control pins.

## Interface

Parameters:
- `ALU_PASS_B`, default 3'b000: ALU select code that drives `y = b`. Used to load the accumulator.

Ports:
- `clk` in 1: system clock, rising edge.
- `clr` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `instr` in 12: instruction word, described under Operation.
- `instr_valid` in 1: `instr` is valid this cycle.
- `instr_ready` out 1: controller can accept an instruction.
- `done` out 1: one-cycle pulse when an instruction completes.
- `dp_w` out 3: datapath register-write mux select, 1 = accumulator.
- `dp_ce` out 4: datapath enables; [2:0] = r0..r2, [3] = accumulator.
- `dp_sel` out 2: ALU B-operand select; 3 = zero.
- `dp_s` out 3: ALU operation code.
- `dp_cin` out 1: ALU carry-in.
- `dp_clr` out 1: datapath clear, active-high.

## Operation

Instruction fields:
- [11:10] class: 00 NOP, 01 LOADM, 10 ALU, 11 CLEAR.
- ALU class: [9:7] op, [6] cin, [5:4] src_a, [3:2] src_b, [1:0] dst.
- LOADM class: [2:0] mask.
- Unused bits are ignored.

Handshake:
- An instruction is accepted on a rising edge where `instr_valid && instr_ready`.
- The instruction is latched into an internal register at acceptance; `instr` may change afterwards.
- `instr_ready` = 1 only in IDLE.

States: IDLE, LDA, EXE, WB, LDM, CLR, NOP.

Transitions out of IDLE on acceptance:
- ALU → LDA.
- LOADM → LDM.
- CLEAR → CLR.
- NOP → NOP.

Remaining transitions:
- LDA → EXE.
- EXE → WB if dst ≠ 3; otherwise EXE → IDLE.
- WB, LDM, CLR, NOP → IDLE.

Outputs are decoded from the state register and the latched instruction only; they have no combinational path from `instr`. Idle values, used in IDLE and in any state not listed below: `dp_w`=000, `dp_ce`=0000, `dp_sel`=11, `dp_s`=`ALU_PASS_B`, `dp_cin`=0, `dp_clr`=0.

Per-state drive:
- LDA: `dp_sel`=src_a, `dp_s`=`ALU_PASS_B`, `dp_ce[3]`=1. Result: acc ← src_a, where src 3 loads zero.
- EXE: `dp_sel`=src_b, `dp_s`=op, `dp_cin`=cin, `dp_ce[3]`=1. Result: acc ← ALU(acc, src_b).
- WB: `dp_w[dst]`=1, `dp_ce[dst]`=1. Result: r[dst] ← acc.
- LDM: `dp_w`=000, `dp_ce[2:0]`=mask. Registers with mask bit set load m0..m2. Mask 000 is legal and performs no write.
- CLR: `dp_clr`=1.
- NOP: no strobes.

`done` is a registered output. It is high for exactly the one cycle after the final state, i.e. the first cycle back in IDLE.

## Timing

Reset (`clr`=0, asynchronous):
- State → IDLE; latched instruction → 0; `done`=0.
- All datapath controls take their idle values.
- `instr_ready`=1 from the first cycle after release.
- Reset mid-instruction abandons it: no further strobes and no `done`.

Latency from the acceptance edge to the `done` cycle, counted in cycles:
- ALU with write-back: 4.
- ALU with dst = 3: 3.
- LOADM, CLEAR, NOP: 2.

Throughput and handshake rules:
- Back-to-back: a new instruction may be accepted in the `done` cycle, because ready = 1 then. Maximum throughput is one instruction per 2 cycles for single-step classes.
- `instr_valid` held while busy is neither lost nor double-accepted. It is taken on the first IDLE edge.
- No instruction is ever in flight while `instr_ready` = 1.

## Structure

Shared package `pmctrl_pkg`:
- Class codes (NOP/LOADM/ALU/CLEAR).
- State enum.
- Instruction field bit positions.
- Idle-value constants for the datapath control bundle.

Optional sub-module `pmctrl_decode`: combinational state+instruction → control bundle. Keep it a separate file so it can be reused by a later pipelined controller.

## Test plan

- Reset: hold `clr`=0 while `instr_valid`=1 → all outputs at idle values, `done`=0. Release → `instr_ready`=1; the instruction is accepted on the first edge after release.
- ALU instruction with op=the ALU add code, cin=0, src_a=0, src_b=1, dst=2, and r0=3, r1=4 in an integrated `pmdatapath` bench:
  - Strobes in order: LDA (sel=00, ce=1000), EXE (sel=01, ce=1000), WB (w=100, ce=0100).
  - Result: r2=7, `done` 4 cycles after acceptance.
- Same instruction with dst=3 → no WB cycle, `dp_ce[2:0]` never set, `done` 3 cycles after acceptance, acc=7.
- LOADM with mask=101 and m0=9, m2=5:
  - One cycle with `dp_w`=000, `dp_ce`=0101.
  - Result: r0=9, r2=5, r1 unchanged, `done` next cycle.
- Back-to-back:
  - CLEAR accepted, then NOP presented in the CLEAR `done` cycle and accepted there.
  - `dp_clr` high exactly 1 cycle; two `done` pulses 2 cycles apart.
  - Valid held during busy cycles causes no extra acceptance.
- Reset mid-op: assert `clr` during EXE of an ALU instruction with dst=1 → controls idle immediately, r1 never written, no `done` pulse.

Source files
------------

// File: rtl/pmctrl_pkg.sv
// Shared types and constants for the pmdatapath instruction sequencer.
// Field positions refer to the 12-bit instruction word.
package pmctrl_pkg;

    typedef enum logic [1:0] {
        CL_NOP   = 2'b00,
        CL_LOADM = 2'b01,
        CL_ALU   = 2'b10,
        CL_CLEAR = 2'b11
    } cls_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LDA  = 3'd1,
        ST_EXE  = 3'd2,
        ST_WB   = 3'd3,
        ST_LDM  = 3'd4,
        ST_CLR  = 3'd5,
        ST_NOP  = 3'd6
    } state_e;

    localparam int CLS_HI  = 11;
    localparam int CLS_LO  = 10;
    localparam int OP_HI   = 9;
    localparam int OP_LO   = 7;
    localparam int CIN_B   = 6;
    localparam int SA_HI   = 5;
    localparam int SA_LO   = 4;
    localparam int SB_HI   = 3;
    localparam int SB_LO   = 2;
    localparam int DST_HI  = 1;
    localparam int DST_LO  = 0;
    localparam int MASK_HI = 2;
    localparam int MASK_LO = 0;

    localparam logic [1:0] DST_NONE = 2'b11;

    typedef struct packed {
        logic [2:0] w;
        logic [3:0] ce;
        logic [1:0] sel;
        logic [2:0] s;
        logic       cin;
        logic       clr;
    } ctrl_t;

    localparam logic [2:0] W_IDLE   = 3'b000;
    localparam logic [3:0] CE_IDLE  = 4'b0000;
    localparam logic [1:0] SEL_IDLE = 2'b11;
    localparam logic       CIN_IDLE = 1'b0;
    localparam logic       CLR_IDLE = 1'b0;

    // The ALU pass-through code is a block parameter, so it is supplied here.
    function automatic ctrl_t ctrl_idle(input logic [2:0] pass_b);
        ctrl_t c;
        c.w   = W_IDLE;
        c.ce  = CE_IDLE;
        c.sel = SEL_IDLE;
        c.s   = pass_b;
        c.cin = CIN_IDLE;
        c.clr = CLR_IDLE;
        return c;
    endfunction

endpackage

// File: rtl/pmctrl_decode.sv
// Combinational decode of sequencer state plus latched instruction
// into the datapath control bundle.
module pmctrl_decode
    import pmctrl_pkg::*;
#(
    parameter logic [2:0] ALU_PASS_B = 3'b000
) (
    input  logic [2:0] i_state,
    input  logic [9:0] i_instr,
    output logic [2:0] o_w,
    output logic [3:0] o_ce,
    output logic [1:0] o_sel,
    output logic [2:0] o_s,
    output logic       o_cin,
    output logic       o_clr
);

    ctrl_t      w_ctrl;
    logic [1:0] w_dst;

    assign w_dst = i_instr[DST_HI:DST_LO];

    always_comb begin
        w_ctrl = ctrl_idle(ALU_PASS_B);
        unique case (state_e'(i_state))
            ST_LDA: begin
                w_ctrl.sel   = i_instr[SA_HI:SA_LO];
                w_ctrl.ce[3] = 1'b1;
            end
            ST_EXE: begin
                w_ctrl.sel   = i_instr[SB_HI:SB_LO];
                w_ctrl.s     = i_instr[OP_HI:OP_LO];
                w_ctrl.cin   = i_instr[CIN_B];
                w_ctrl.ce[3] = 1'b1;
            end
            ST_WB: begin
                // dst of 3 shifts the strobe out entirely
                w_ctrl.w       = 3'b001 << w_dst;
                w_ctrl.ce[2:0] = 3'b001 << w_dst;
            end
            ST_LDM: begin
                w_ctrl.w       = 3'b000;
                w_ctrl.ce[2:0] = i_instr[MASK_HI:MASK_LO];
            end
            ST_CLR: begin
                w_ctrl.clr = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign o_w   = w_ctrl.w;
    assign o_ce  = w_ctrl.ce;
    assign o_sel = w_ctrl.sel;
    assign o_s   = w_ctrl.s;
    assign o_cin = w_ctrl.cin;
    assign o_clr = w_ctrl.clr;

endmodule

// File: rtl/pmctrl.sv
// Instruction sequencer driving the pmdatapath control pins over
// a valid/ready instruction handshake.
module pmctrl
    import pmctrl_pkg::*;
#(
    parameter logic [2:0] ALU_PASS_B = 3'b000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [11:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic        done,
    output logic [2:0]  dp_w,
    output logic [3:0]  dp_ce,
    output logic [1:0]  dp_sel,
    output logic [2:0]  dp_s,
    output logic        dp_cin,
    output logic        dp_clr
);

    state_e     r_state;
    state_e     w_next;
    state_e     w_start;
    logic [9:0] r_instr;
    logic       r_done;
    logic       w_accept;
    logic       w_last;

    assign instr_ready = (r_state == ST_IDLE);
    assign w_accept    = instr_valid && instr_ready;

    always_comb begin
        w_start = ST_NOP;
        unique case (cls_e'(instr[CLS_HI:CLS_LO]))
            CL_ALU:   w_start = ST_LDA;
            CL_LOADM: w_start = ST_LDM;
            CL_CLEAR: w_start = ST_CLR;
            CL_NOP:   w_start = ST_NOP;
            default:  w_start = ST_NOP;
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept) w_next = w_start;
            ST_LDA:  w_next = ST_EXE;
            ST_EXE: begin
                if (r_instr[DST_HI:DST_LO] != DST_NONE)
                    w_next = ST_WB;
                else
                    w_next = ST_IDLE;
            end
            ST_WB:   w_next = ST_IDLE;
            ST_LDM:  w_next = ST_IDLE;
            ST_CLR:  w_next = ST_IDLE;
            ST_NOP:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // done fires in the first IDLE cycle after any busy state
    assign w_last = (r_state != ST_IDLE) && (w_next == ST_IDLE);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= ST_IDLE;
            r_instr <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_last;
            if (w_accept)
                r_instr <= instr[9:0];
        end
    end

    assign done = r_done;

    pmctrl_decode #(
        .ALU_PASS_B(ALU_PASS_B)
    ) u_decode (
        .i_state (r_state),
        .i_instr (r_instr),
        .o_w     (dp_w),
        .o_ce    (dp_ce),
        .o_sel   (dp_sel),
        .o_s     (dp_s),
        .o_cin   (dp_cin),
        .o_clr   (dp_clr)
    );

endmodule

// File: tb/tb_pmctrl.sv
// Directed bench for pmctrl: vector table plus hand-written
// reset, back-to-back and mid-operation reset sequences.
module tb_pmctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic [11:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        done;
    logic [2:0]  dp_w;
    logic [3:0]  dp_ce;
    logic [1:0]  dp_sel;
    logic [2:0]  dp_s;
    logic        dp_cin;
    logic        dp_clr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pmctrl dut (
        .clk         (clk),
        .clr         (clr),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .done        (done),
        .dp_w        (dp_w),
        .dp_ce       (dp_ce),
        .dp_sel      (dp_sel),
        .dp_s        (dp_s),
        .dp_cin      (dp_cin),
        .dp_clr      (dp_clr)
    );

    typedef struct {
        string       nm;
        logic [11:0] ins;
        int          n;
        logic [13:0] c0;
        logic [13:0] c1;
        logic [13:0] c2;
    } vec_t;

    vec_t v [8];

    function automatic logic [13:0] pk(
        input logic [2:0] w, input logic [3:0] ce, input logic [1:0] sel,
        input logic [2:0] s, input logic cin, input logic cl);
        return {w, ce, sel, s, cin, cl};
    endfunction

    logic [13:0] idle;
    logic [13:0] act;
    assign act = {dp_w, dp_ce, dp_sel, dp_s, dp_cin, dp_clr};

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, a, e);
        end
    endtask

    initial begin
        logic [13:0] exp_c;
        idle = pk(3'b000, 4'b0000, 2'b11, 3'b000, 1'b0, 1'b0);

        v[0] = '{"alu_add_r2", 12'h906, 3,
                 pk(0, 4'b1000, 0, 0, 0, 0),
                 pk(0, 4'b1000, 1, 3'b010, 0, 0),
                 pk(3'b100, 4'b0100, 3, 0, 0, 0)};
        v[1] = '{"alu_dst3", 12'h907, 2,
                 pk(0, 4'b1000, 0, 0, 0, 0),
                 pk(0, 4'b1000, 1, 3'b010, 0, 0),
                 idle};
        v[2] = '{"alu_cin_r0", 12'hAF8, 3,
                 pk(0, 4'b1000, 3, 0, 0, 0),
                 pk(0, 4'b1000, 2, 3'b101, 1, 0),
                 pk(3'b001, 4'b0001, 3, 0, 0, 0)};
        v[3] = '{"ldm_101", 12'h405, 1,
                 pk(0, 4'b0101, 3, 0, 0, 0), idle, idle};
        v[4] = '{"ldm_000", 12'h400, 1, idle, idle, idle};
        v[5] = '{"ldm_junk", 12'h7FD, 1,
                 pk(0, 4'b0101, 3, 0, 0, 0), idle, idle};
        v[6] = '{"clear_junk", 12'hFFF, 1,
                 pk(0, 0, 3, 0, 0, 1), idle, idle};
        v[7] = '{"nop_junk", 12'h3FF, 1, idle, idle, idle};

        // reset held with a valid instruction pending
        clr = 1'b1;
        instr = 12'hC00;
        instr_valid = 1'b1;
        #1 clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", act, idle);
        chk("rst_done", done, 0);
        clr = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("rst_first_acc", act, pk(0, 0, 3, 0, 0, 1));
        chk("rst_first_rdy", instr_ready, 0);
        @(negedge clk);
        chk("rst_first_done", done, 1);

        for (int i = 0; i < 8; i++) begin
            chk({v[i].nm, "_rdy"}, instr_ready, 1);
            instr = v[i].ins;
            instr_valid = 1'b1;
            @(negedge clk);
            instr_valid = 1'b0;
            instr = ~v[i].ins;
            for (int k = 0; k < v[i].n; k++) begin
                exp_c = (k == 0) ? v[i].c0 : (k == 1) ? v[i].c1 : v[i].c2;
                chk($sformatf("%s_c%0d", v[i].nm, k), act, exp_c);
                chk($sformatf("%s_busy%0d", v[i].nm, k), instr_ready, 0);
                chk($sformatf("%s_nd%0d", v[i].nm, k), done, 0);
                @(negedge clk);
            end
            chk({v[i].nm, "_done"}, done, 1);
            chk({v[i].nm, "_idle"}, act, idle);
        end

        // back-to-back CLEAR then NOP with valid held through busy
        instr = 12'hC00;
        instr_valid = 1'b1;
        @(negedge clk);
        instr = 12'h000;
        chk("b2b_clr", dp_clr, 1);
        chk("b2b_busy", instr_ready, 0);
        @(negedge clk);
        chk("b2b_done1", done, 1);
        chk("b2b_clr_off", dp_clr, 0);
        chk("b2b_rdy", instr_ready, 1);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("b2b_nop_busy", instr_ready, 0);
        chk("b2b_nop_nd", done, 0);
        chk("b2b_nop_ctrl", act, idle);
        @(negedge clk);
        chk("b2b_done2", done, 1);
        @(negedge clk);
        chk("b2b_no_extra_rdy", instr_ready, 1);
        chk("b2b_no_extra_done", done, 0);

        // reset during EXE of an ALU op writing r1
        instr = 12'h905;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("mid_lda", act, pk(0, 4'b1000, 0, 0, 0, 0));
        @(negedge clk);
        chk("mid_exe", act, pk(0, 4'b1000, 1, 3'b010, 0, 0));
        #2 clr = 1'b0;
        #1;
        chk("mid_rst_ctrl", act, idle);
        chk("mid_rst_done", done, 0);
        @(negedge clk);
        clr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("mid_after_ctrl%0d", k), act, idle);
            chk($sformatf("mid_after_done%0d", k), done, 0);
        end
        chk("mid_after_rdy", instr_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
